// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage together with the IF/ID pipeline register.
//
// The stage owns the fetch PC and talks to instruction memory with a simple
// req/ack handshake. Every cycle it presents {pc, instruction, valid} to the
// decode logic. It obeys a stall from the hazard unit and a redirect
// (taken branch) from the MEM stage. A single-word skid buffer holds a
// fetched instruction that arrived while decode was stalled.
//
// Ports
//   clock          in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   stall          in   1   hold IF/ID contents (hazard unit)
//   branch_taken   in   1   redirect fetch (MEM stage)
//   branch_target  in  64   redirect address, valid with branch_taken
//   imem_req       out  1   fetch request
//   imem_addr      out 64   fetch address (always the fetch PC)
//   imem_ack       in   1   response valid this cycle (only while imem_req=1)
//   imem_rdata     in  32   instruction word, valid with imem_ack
//   pc             out 64   IF/ID: address of the instruction
//   instruction    out 32   IF/ID: instruction word
//   valid          out  1   IF/ID: 1 = real instruction, 0 = bubble
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [63:0] PC_STEP   = 64'd4,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [63:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);

  // FLUSH: one idle cycle after reset or redirect, no request issued.
  // FETCH: request outstanding at fetch_pc.
  // HOLD : a word was accepted while stalled and sits in the skid buffer.
  localparam logic [1:0] FLUSH = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [63:0] fetch_pc;
  logic [31:0] skid;
  logic [63:0] next_pc;

  // Sequential fetch address; plain 64-bit addition wraps modulo 2^64.
  assign next_pc = fetch_pc + PC_STEP;

  // The request depends on state only, so an ack arriving while the
  // request is low (FLUSH/HOLD) never reaches any of the logic below.
  assign imem_req  = (state == FETCH);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      state       <= FLUSH;
      skid        <= 32'h0;
      pc          <= 64'h0;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else if (branch_taken) begin
      // A redirect beats stall: any same-cycle ack and the skid word are
      // dropped, and IF/ID is flushed to a bubble.
      fetch_pc    <= branch_target;
      state       <= FLUSH;
      skid        <= 32'h0;
      pc          <= 64'h0;
      instruction <= NOP_INSTR;
      valid       <= 1'b0;
    end else begin
      case (state)
        FLUSH: begin
          state <= FETCH;
          if (!stall) begin
            pc          <= 64'h0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
          end
        end

        FETCH: begin
          if (imem_ack) begin
            if (!stall) begin
              pc          <= fetch_pc;
              instruction <= imem_rdata;
              valid       <= 1'b1;
              fetch_pc    <= next_pc;
            end else begin
              // Decode cannot take the word yet; park it and stop requesting.
              // fetch_pc still names the parked word, so it advances later.
              skid  <= imem_rdata;
              state <= HOLD;
            end
          end else if (!stall) begin
            pc          <= 64'h0;
            instruction <= NOP_INSTR;
            valid       <= 1'b0;
          end
        end

        HOLD: begin
          if (!stall) begin
            pc          <= fetch_pc;
            instruction <= skid;
            valid       <= 1'b1;
            fetch_pc    <= next_pc;
            state       <= FETCH;
          end
        end

        default: begin
          state <= FLUSH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Directed bench for if_stage. Each applyStimulus call drives one cycle of
// inputs and queues the outputs expected during that same cycle (the state
// left by the previous edge). A monitor on the falling edge pops each entry
// and compares it against the DUT.
// ---------------------------------------------------------------------------
module tb_if_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [63:0] pc;
  logic [31:0] instruction;
  logic        valid;

  typedef struct {
    string       name;
    logic        req;
    logic [63:0] addr;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  if_stage #(
    .RESET_PC (64'h0),
    .PC_STEP  (64'd4),
    .NOP_INSTR(NOP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .instruction  (instruction),
    .valid        (valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input exp_t e);
    checks++;
    if (imem_req !== e.req || imem_addr !== e.addr || pc !== e.pc ||
        instruction !== e.instr || valid !== e.valid) begin
      errors++;
      $display("[TB] FAIL %s: got req=%0b addr=%h pc=%h instr=%h valid=%0b, expected req=%0b addr=%h pc=%h instr=%h valid=%0b",
               e.name, imem_req, imem_addr, pc, instruction, valid,
               e.req, e.addr, e.pc, e.instr, e.valid);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput(e);
    end
  end

  task automatic applyStimulus(
    input string       name,
    input logic        rst,
    input logic        stl,
    input logic        br,
    input logic [63:0] tgt,
    input logic        ack,
    input logic [31:0] rdata,
    input logic        e_req,
    input logic [63:0] e_addr,
    input logic [63:0] e_pc,
    input logic [31:0] e_instr,
    input logic        e_valid
  );
    exp_t e;
    reset         = rst;
    stall         = stl;
    branch_taken  = br;
    branch_target = tgt;
    imem_ack      = ack;
    imem_rdata    = rdata;
    e.name  = name;
    e.req   = e_req;
    e.addr  = e_addr;
    e.pc    = e_pc;
    e.instr = e_instr;
    e.valid = e_valid;
    exp_q.push_back(e);
    @(posedge clock);
    #2;
  endtask

  initial begin
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    repeat (2) @(posedge clock);
    #2;

    //            name             rst stl br  target                 ack rdata          req addr                   pc                     instr          v
    // Reset and sequential fetch
    applyStimulus("reset_state",   0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'h0,                 64'h0,                 NOP,           0);
    applyStimulus("first_req",     0, 0, 0, 64'h0,                 1, 32'h00001000, 1, 64'h0,                 64'h0,                 NOP,           0);
    applyStimulus("seq_0",         0, 0, 0, 64'h0,                 1, 32'h00001004, 1, 64'h4,                 64'h0,                 32'h00001000,  1);
    // Wait states at 0x8
    applyStimulus("seq_4",         0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 1, 64'h8,                 64'h4,                 32'h00001004,  1);
    applyStimulus("wait_1",        0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 1, 64'h8,                 64'h0,                 NOP,           0);
    applyStimulus("wait_2",        0, 0, 0, 64'h0,                 1, 32'h00001008, 1, 64'h8,                 64'h0,                 NOP,           0);
    // Stall arriving with the ack at 0xC: word goes to the skid buffer
    applyStimulus("after_wait",    0, 1, 0, 64'h0,                 1, 32'h0000100C, 1, 64'hC,                 64'h8,                 32'h00001008,  1);
    applyStimulus("hold_1",        0, 1, 0, 64'h0,                 1, 32'hBADBAD00, 0, 64'hC,                 64'h8,                 32'h00001008,  1);
    applyStimulus("hold_2",        0, 1, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'hC,                 64'h8,                 32'h00001008,  1);
    applyStimulus("hold_release",  0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'hC,                 64'h8,                 32'h00001008,  1);
    // Stall with no ack holds IF/ID; then redirect while waiting on 0x10
    applyStimulus("skid_out",      0, 1, 0, 64'h0,                 0, 32'hDEADBEEF, 1, 64'h10,                64'hC,                 32'h0000100C,  1);
    applyStimulus("stall_noack",   0, 0, 1, 64'h200,               1, 32'h00001010, 1, 64'h10,                64'hC,                 32'h0000100C,  1);
    applyStimulus("redir_flush",   0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'h200,               64'h0,                 NOP,           0);
    applyStimulus("redir_req",     0, 0, 0, 64'h0,                 1, 32'h00001200, 1, 64'h200,               64'h0,                 NOP,           0);
    // Enter HOLD, then redirect with stall still high: skid word is lost
    applyStimulus("redir_first",   0, 1, 0, 64'h0,                 1, 32'h00001204, 1, 64'h204,               64'h200,               32'h00001200,  1);
    applyStimulus("hold_redir",    0, 1, 1, 64'h40,                0, 32'hDEADBEEF, 0, 64'h204,               64'h200,               32'h00001200,  1);
    applyStimulus("hredir_flush",  0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'h40,                64'h0,                 NOP,           0);
    applyStimulus("hredir_req",    0, 0, 0, 64'h0,                 1, 32'h00001040, 1, 64'h40,                64'h0,                 NOP,           0);
    // Enter HOLD again, then reset out of it
    applyStimulus("hredir_first",  0, 1, 0, 64'h0,                 1, 32'h00001044, 1, 64'h44,                64'h40,                32'h00001040,  1);
    applyStimulus("hold_reset",    1, 1, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'h44,                64'h40,                32'h00001040,  1);
    applyStimulus("post_reset",    0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'h0,                 64'h0,                 NOP,           0);
    applyStimulus("restart_req",   0, 0, 0, 64'h0,                 1, 32'h00001000, 1, 64'h0,                 64'h0,                 NOP,           0);
    // Redirect to the top of the address space and wrap to zero
    applyStimulus("restart_0",     0, 0, 1, 64'hFFFFFFFFFFFFFFFC,  0, 32'hDEADBEEF, 1, 64'h4,                 64'h0,                 32'h00001000,  1);
    applyStimulus("wrap_flush",    0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 0, 64'hFFFFFFFFFFFFFFFC,  64'h0,                 NOP,           0);
    applyStimulus("wrap_req",      0, 0, 0, 64'h0,                 1, 32'hAAAA0000, 1, 64'hFFFFFFFFFFFFFFFC,  64'h0,                 NOP,           0);
    applyStimulus("wrap_to_zero",  0, 0, 0, 64'h0,                 1, 32'h00001000, 1, 64'h0,                 64'hFFFFFFFFFFFFFFFC,  32'hAAAA0000,  1);
    applyStimulus("after_wrap",    0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 1, 64'h4,                 64'h0,                 32'h00001000,  1);
    applyStimulus("final_bubble",  0, 0, 0, 64'h0,                 0, 32'hDEADBEEF, 1, 64'h4,                 64'h0,                 NOP,           0);

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Sits directly upstream of id_ex, through the decode logic.
- Owns the fetch PC and runs a req/ack handshake with instruction memory. Presents {pc, instruction, valid} to decode each cycle.
- Obeys stall from the hazard unit and redirect (taken branch) from the MEM stage. Holds one fetched word in a skid buffer when decode is stalled.

Parameters:
- RESET_PC, 64'h0, fetch address after reset.
- PC_STEP, 4, byte increment per sequential fetch.
- NOP_INSTR, 32'hD503201F, encoding driven on instruction for bubbles/flushes.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold IF/ID contents.
- branch_taken  in  1  MEM stage: redirect fetch.
- branch_target  in  64  redirect address, valid with branch_taken.
- imem_req  out  1  fetch request.
- imem_addr  out  64  fetch address (= fetch_pc).
- imem_ack  in  1  response valid this cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- pc  out  64  IF/ID: address of instruction.
- instruction  out  32  IF/ID: instruction word.
- valid  out  1  IF/ID: 1 = real instruction, 0 = bubble.

Behaviour:
- Reset is a single synchronous reset with active-high polarity on the same clock.
- On reset:
  - fetch_pc=RESET_PC; state=FLUSH.
  - pc=0, instruction=NOP_INSTR, valid=0; skid buffer cleared.
- Registered state: fetch_pc[63:0], state{FLUSH,FETCH,HOLD}, skid[31:0].
- imem_req is decoded from state only: imem_req=1 iff state==FETCH. imem_addr=fetch_pc at all times.
- Memory contract:
  - imem_addr is stable while imem_req=1 until ack.
  - Deasserting imem_req abandons the transaction; an ack in a cycle with imem_req=0 is ignored.
- Priority per edge: reset > branch_taken > stall > normal.
- branch_taken=1, any state:
  - fetch_pc<=branch_target; state<=FLUSH.
  - IF/ID<= {pc=0, NOP_INSTR, valid=0}; skid discarded.
  - A same-cycle imem_ack is discarded.
- FLUSH: imem_req=0 for exactly one cycle. Next state FETCH (unless redirected again). IF/ID loads a bubble unless stall=1, in which case IF/ID holds.
- FETCH, imem_ack=1, stall=0:
  - IF/ID<= {fetch_pc, imem_rdata, 1}.
  - fetch_pc<=fetch_pc+PC_STEP; stay FETCH.
  - Back-to-back zero-wait acks sustain 1 instr/cycle.
- FETCH, imem_ack=1, stall=1: skid<=imem_rdata; IF/ID holds; state<=HOLD. fetch_pc is not incremented yet.
- FETCH, imem_ack=0: fetch_pc and imem_addr are unchanged.
  - stall=0: IF/ID<=bubble (pc=0, NOP_INSTR, valid=0).
  - stall=1: IF/ID holds.
- HOLD: imem_req=0.
  - stall=1: everything holds.
  - stall=0: IF/ID<= {fetch_pc, skid, 1}; fetch_pc<=fetch_pc+PC_STEP; state<=FETCH.
- Latency: instruction appears on IF/ID outputs at the edge on which ack is sampled (zero-wait memory gives one cycle from request to decode).
- Arithmetic: fetch_pc increment is 64-bit modulo 2^64; 0xFFFF_FFFF_FFFF_FFFC wraps to 0. branch_target is used unmodified, with no alignment check.
- Stall never blocks a redirect. Redirect during HOLD drops the buffered word.
- Illegal: none. All input combinations are defined above.

Test Plan:
- Reset/sequential:
  - Stimulus: RESET_PC=0, zero-wait memory with mem[a]=a+32'h1000; reset 2 cycles.
  - Response: first post-reset cycle imem_req=0. Then successive edges give (pc,instruction,valid) = (0,0x1000,1), (4,0x1004,1), (8,0x1008,1).
- Wait states:
  - Stimulus: ack delayed 2 cycles at addr 0x8.
  - Response: imem_addr held at 0x8 for 3 cycles; two edges with valid=0, instruction=NOP_INSTR; then (8,0x1008,1); next imem_addr=0xC.
- Stall with ack:
  - Stimulus: stall=1 for 3 cycles starting the cycle addr 0x8 is acked.
  - Response: IF/ID holds (4,0x1004,1); imem_req=0 on the 2 following cycles. Edge after stall drops gives (8,0x1008,1); then req at 0xC.
- Redirect mid-wait:
  - Stimulus: waiting on 0x10, branch_taken=1 with target 0x200, ack asserted the same cycle.
  - Response: ack ignored; IF/ID=(0,NOP_INSTR,0); one cycle imem_req=0; then imem_req=1 at 0x200; first valid output pc=0x200.
- Redirect plus stall in HOLD:
  - Stimulus: in HOLD with skid=0x1008, stall=1, branch_taken=1 with target 0x40.
  - Response: skid discarded; valid=0; next request 0x40; 0x1008 never appears.
- Reset mid-HOLD and wrap-around:
  - Reset asserted in HOLD → all outputs return to reset values; fetch restarts at RESET_PC.
  - Separately, redirect to 0xFFFF_FFFF_FFFF_FFFC → next sequential imem_addr=0.
